// File: rtl/usart_ex.sv
// usart_ex: second-generation bus-attached serial port with programmable
// divisor, 16x oversampled majority-vote receive, 5-8 data bits, optional
// parity, 1/2 stop bits, sticky error flags and maskable interrupt.

// Byte-wide FIFO with priority clear; push when full and pop when empty are ignored.
module usart_ex_fifo #(
  parameter int aw = 9
) (
  input  logic       busclk_i,
  input  logic       reset_i,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  logic [7:0]  mem [2**aw];
  logic [aw:0] wr_ptr, rd_ptr;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign dout  = mem[rd_ptr[aw-1:0]];

  // Storage write.
  // NOTE: the memory array is deliberately not reset; emptiness is defined by the pointers alone.
  always_ff @(posedge busclk_i) begin
    if (push && !full && !clr) mem[wr_ptr[aw-1:0]] <= din;
  end

  // Pointer update; clear beats a simultaneous push or pop.
  always_ff @(posedge busclk_i) begin
    if (reset_i || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (aw+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (aw+1)'(1);
    end
  end
endmodule

module usart_ex #(
  parameter int          fifo_log2   = 9,
  parameter logic [15:0] default_div = 16'd5
) (
  input  logic       busclk_i,
  input  logic       reset_i,
  output logic       tx_o,
  input  logic       rx_i,
  input  logic [2:0] A_i,
  input  logic [7:0] D_i,
  output logic [7:0] D_o,
  input  logic       nWR_i,
  input  logic       nRD_i,
  output logic       interrupt_o
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic        nwr_q, nrd_q, wr_stb, rd_rel, clr_all, stat_clr, rx_pop, tx_push;
  logic [2:0]  rd_addr_q;
  logic [15:0] div_q, presc_q;
  logic [4:0]  cfg_q;
  logic [2:0]  ie_q, err_q;
  logic        tick;
  logic [7:0]  tx_dout, rx_dout, tx_mask, status;
  logic        tx_empty, tx_full, rx_empty, rx_full;

  assign wr_stb   = !nWR_i && nwr_q;
  assign rd_rel   = nRD_i && !nrd_q;
  assign clr_all  = wr_stb && (A_i == 3'd1) && D_i[7];
  assign stat_clr = clr_all || (rd_rel && (rd_addr_q == 3'd1));
  assign rx_pop   = rd_rel && (rd_addr_q == 3'd0);
  assign tx_push  = wr_stb && (A_i == 3'd0);
  assign tick     = presc_q == 16'd0;

  // Strobe edge detection; the read address is held so the release acts on the strobed register.
  // NOTE: sequential state is always updated with <=, so every block sees pre-edge values.
  always_ff @(posedge busclk_i) begin
    if (reset_i) begin
      nwr_q     <= 1'b1;
      nrd_q     <= 1'b1;
      rd_addr_q <= 3'd0;
    end else begin
      nwr_q <= nWR_i;
      nrd_q <= nRD_i;
      if (!nRD_i) rd_addr_q <= A_i;
    end
  end

  // Configuration registers.
  always_ff @(posedge busclk_i) begin
    if (reset_i) begin
      div_q <= default_div;
      cfg_q <= 5'h03;
      ie_q  <= 3'h0;
    end else if (wr_stb) begin
      case (A_i)
        3'd2:    div_q[7:0]  <= D_i;
        3'd3:    div_q[15:8] <= D_i;
        3'd4:    cfg_q       <= D_i[4:0];
        3'd5:    ie_q        <= D_i[2:0];
        default: ;
      endcase
    end
  end

  // Oversample prescaler: down-counter, reloads from the divisor register at zero.
  always_ff @(posedge busclk_i) begin
    if (reset_i)   presc_q <= default_div;
    else if (tick) presc_q <= div_q;
    else           presc_q <= presc_q - 16'd1;
  end

  // ---------------- transmitter ----------------
  state_t     tx_state;
  logic [3:0] tx_ph;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic [1:0] tx_nb_q;
  logic       tx_par, tx_pen_q, tx_stop2_q, tx_second, tx_last_stop, tx_load, tx_busy;

  assign tx_busy      = tx_state != S_IDLE;
  assign tx_mask      = 8'hFF >> (2'd3 - cfg_q[1:0]);
  assign tx_last_stop = !tx_stop2_q || tx_second;
  assign tx_load      = tick && !tx_empty &&
                        ((tx_state == S_IDLE) ||
                         ((tx_state == S_STOP) && (tx_ph == 4'd15) && tx_last_stop));

  usart_ex_fifo #(.aw(fifo_log2)) u_tx_fifo (
    .busclk_i(busclk_i), .reset_i(reset_i), .clr(clr_all), .push(tx_push), .pop(tx_load),
    .din(D_i), .dout(tx_dout), .empty(tx_empty), .full(tx_full)
  );

  // TX frame sequencer; a load on a tick keeps every bit exactly 16 ticks and frames gapless.
  always_ff @(posedge busclk_i) begin
    if (reset_i || clr_all) begin
      tx_state   <= S_IDLE;
      tx_o       <= 1'b1;
      tx_ph      <= 4'd0;
      tx_bit     <= 3'd0;
      tx_sh      <= 8'd0;
      tx_par     <= 1'b0;
      tx_nb_q    <= 2'd3;
      tx_pen_q   <= 1'b0;
      tx_stop2_q <= 1'b0;
      tx_second  <= 1'b0;
    end else if (tx_load) begin
      tx_state   <= S_START;
      tx_o       <= 1'b0;
      tx_ph      <= 4'd0;
      tx_sh      <= tx_dout & tx_mask;
      tx_par     <= ^(tx_dout & tx_mask) ^ cfg_q[3];
      tx_nb_q    <= cfg_q[1:0];
      tx_pen_q   <= cfg_q[2];
      tx_stop2_q <= cfg_q[4];
      tx_second  <= 1'b0;
    end else if (tx_busy && tick) begin
      tx_ph <= tx_ph + 4'd1;
      if (tx_ph == 4'd15) begin
        case (tx_state)
          S_START: begin
            tx_state <= S_DATA;
            tx_bit   <= 3'd0;
            tx_o     <= tx_sh[0];
          end
          S_DATA: begin
            if (tx_bit == {1'b0, tx_nb_q} + 3'd4) begin
              tx_state <= tx_pen_q ? S_PARITY : S_STOP;
              tx_o     <= tx_pen_q ? tx_par : 1'b1;
            end else begin
              tx_bit <= tx_bit + 3'd1;
              tx_sh  <= tx_sh >> 1;
              tx_o   <= tx_sh[1];
            end
          end
          S_PARITY: begin
            tx_state <= S_STOP;
            tx_o     <= 1'b1;
          end
          S_STOP: begin
            if (tx_last_stop) tx_state <= S_IDLE;
            else              tx_second <= 1'b1;
          end
          default: tx_state <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  state_t     rx_state;
  logic       rx_s1, rx_s2, rx_s3, rx_maj, rx_push_q, rx_par_set, rx_frm_set, ovr_set;
  logic       rx_pen_q, rx_odd_q;
  logic [1:0] rx_nb_q, rx_smp;
  logic [3:0] rx_ph;
  logic [2:0] rx_bit;
  logic [7:0] rx_data;

  assign rx_maj  = (rx_smp[0] & rx_smp[1]) | (rx_smp[0] & rx_s2) | (rx_smp[1] & rx_s2);
  assign ovr_set = rx_push_q && rx_full && !clr_all;

  usart_ex_fifo #(.aw(fifo_log2)) u_rx_fifo (
    .busclk_i(busclk_i), .reset_i(reset_i), .clr(clr_all), .push(rx_push_q), .pop(rx_pop),
    .din(rx_data), .dout(rx_dout), .empty(rx_empty), .full(rx_full)
  );

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge busclk_i) begin
    if (reset_i) {rx_s1, rx_s2, rx_s3} <= 3'b111;
    else         {rx_s1, rx_s2, rx_s3} <= {rx_i, rx_s1, rx_s2};
  end

  // RX frame sequencer: votes ticks 7/8/9 of each bit, advances at tick 15.
  always_ff @(posedge busclk_i) begin
    if (reset_i || clr_all) begin
      rx_state   <= S_IDLE;
      rx_ph      <= 4'd0;
      rx_bit     <= 3'd0;
      rx_data    <= 8'd0;
      rx_smp     <= 2'b11;
      rx_nb_q    <= 2'd3;
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_push_q  <= 1'b0;
      rx_par_set <= 1'b0;
      rx_frm_set <= 1'b0;
    end else begin
      rx_push_q  <= 1'b0;
      rx_par_set <= 1'b0;
      rx_frm_set <= 1'b0;
      if (rx_state == S_IDLE) begin
        if (rx_s3 && !rx_s2) begin
          rx_state <= S_START;
          rx_ph    <= 4'd0;
          rx_bit   <= 3'd0;
          rx_data  <= 8'd0;
          rx_nb_q  <= cfg_q[1:0];
          rx_pen_q <= cfg_q[2];
          rx_odd_q <= cfg_q[3];
        end
      end else if (tick) begin
        rx_ph <= rx_ph + 4'd1;
        if (rx_ph == 4'd7) rx_smp[0] <= rx_s2;
        if (rx_ph == 4'd8) rx_smp[1] <= rx_s2;
        if (rx_ph == 4'd9) begin
          case (rx_state)
            S_START:  if (rx_maj) rx_state <= S_IDLE;
            S_DATA:   rx_data[rx_bit] <= rx_maj;
            S_PARITY: rx_par_set <= (^rx_data ^ rx_maj) != rx_odd_q;
            S_STOP: begin
              rx_push_q  <= 1'b1;
              rx_frm_set <= !rx_maj;
              rx_state   <= S_IDLE;
            end
            default: rx_state <= S_IDLE;
          endcase
        end
        if (rx_ph == 4'd15) begin
          case (rx_state)
            S_START: rx_state <= S_DATA;
            S_DATA: begin
              if (rx_bit == {1'b0, rx_nb_q} + 3'd4) rx_state <= rx_pen_q ? S_PARITY : S_STOP;
              else                                  rx_bit   <= rx_bit + 3'd1;
            end
            S_PARITY: rx_state <= S_STOP;
            default:  ;
          endcase
        end
      end
    end
  end

  // Sticky error flags {framing, parity, overrun}; a new error beats a same-cycle clear.
  always_ff @(posedge busclk_i) begin
    if (reset_i) err_q <= 3'b000;
    else         err_q <= (stat_clr ? 3'b000 : err_q) | {rx_frm_set, rx_par_set, ovr_set};
  end

  // Registered level interrupt.
  always_ff @(posedge busclk_i) begin
    if (reset_i) interrupt_o <= 1'b0;
    else         interrupt_o <= |(ie_q & {|err_q, tx_empty && !tx_busy, !rx_empty});
  end

  assign status = {tx_busy, err_q, tx_full, tx_empty, rx_full, rx_empty};

  // Read-data mux.
  // NOTE: D_o gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    D_o = 8'hFF;
    case (A_i)
      3'd0:    D_o = rx_dout;
      3'd1:    D_o = status;
      3'd2:    D_o = div_q[7:0];
      3'd3:    D_o = div_q[15:8];
      3'd4:    D_o = {3'b000, cfg_q};
      3'd5:    D_o = {5'b00000, ie_q};
      default: D_o = 8'hFF;
    endcase
  end
endmodule

// File: tb/tb_usart_ex.sv
// Directed self-checking bench for usart_ex (4-entry FIFOs to keep the overrun case short).
module tb_usart_ex;
  logic       busclk_i = 1'b0;
  logic       reset_i  = 1'b1;
  logic       rx_i     = 1'b1;
  logic [2:0] A_i      = 3'd0;
  logic [7:0] D_i      = 8'd0;
  logic       nWR_i    = 1'b1;
  logic       nRD_i    = 1'b1;
  logic       tx_o, interrupt_o;
  logic [7:0] D_o;

  int n_cmp = 0;
  int n_bad = 0;

  usart_ex #(.fifo_log2(2), .default_div(16'd5)) dut (
    .busclk_i(busclk_i), .reset_i(reset_i), .tx_o(tx_o), .rx_i(rx_i),
    .A_i(A_i), .D_i(D_i), .D_o(D_o), .nWR_i(nWR_i), .nRD_i(nRD_i),
    .interrupt_o(interrupt_o)
  );

  always #5 busclk_i = ~busclk_i;

  // Negedge cycle counter and tx_o start-bit detector (armed by bumping arm_req).
  int   ncyc     = 0;
  int   fall_cyc = 0;
  int   arm_req  = 0;
  int   fall_id  = 0;
  logic tx_prev  = 1'b1;
  always @(negedge busclk_i) begin
    ncyc = ncyc + 1;
    if (fall_id != arm_req && tx_prev && !tx_o) begin
      fall_cyc = ncyc;
      fall_id  = arm_req;
    end
    tx_prev = tx_o;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge busclk_i);
    #1;
  endtask

  task automatic wait_neg(input int target);
    while (ncyc < target) #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    A_i = a; D_i = d; nWR_i = 1'b0;
    step(1);
    nWR_i = 1'b1;
    step(1);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    A_i = a; nRD_i = 1'b0;
    step(1);
    d = D_o;
    nRD_i = 1'b1;
    step(2);
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_fall(input string tag, output int f);
    int g = 0;
    while (fall_id != arm_req && g < 3000) begin step(1); g++; end
    check(tag, fall_id == arm_req, 1'b1);
    f = fall_cyc;
  endtask

  // bits[k] is the expected tx_o level of bit k; sampled mid-bit relative to the start edge.
  task automatic check_frame(input string tag, input int f, input int per,
                             input logic [31:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      wait_neg(f + per / 2 + k * per);
      check($sformatf("%s_bit%0d", tag, k), tx_o, bits[k]);
    end
  endtask

  // Drives rx_i LSB first, 16 cycles per bit (divisor 0), then idles high.
  task automatic send_rx(input logic [11:0] bits, input int n, input int trail);
    for (int i = 0; i < n; i++) begin
      rx_i = bits[i];
      step(16);
    end
    rx_i = 1'b1;
    step(trail);
  endtask

  function automatic logic [9:0] fr7n2(input logic [7:0] b);
    return {2'b11, b[6:0], 1'b0};
  endfunction

  initial begin
    int   f;
    logic found;

    // ---- reset state ----
    step(3);
    reset_i = 1'b0;
    step(1);
    check("rst_tx_o", tx_o, 1'b1);
    check("rst_irq", interrupt_o, 1'b0);
    A_i = 3'd1; #1;
    check("rst_status", D_o, 8'h05);
    read_check("rst_div_lo", 3'd2, 8'h05);
    read_check("rst_div_hi", 3'd3, 8'h00);
    read_check("rst_cfg", 3'd4, 8'h03);
    read_check("rst_ie", 3'd5, 8'h00);
    read_check("reg6", 3'd6, 8'hFF);

    // ---- TX 0x55 at default divisor: 96-cycle bits ----
    arm_req++;
    bus_write(3'd0, 8'h55);
    wait_fall("tx55_start", f);
    check_frame("tx55", f, 96, {22'd0, 1'b1, 8'h55, 1'b0}, 10);
    A_i = 3'd1;
    wait_neg(f + 959);
    check("tx55_busy_end", D_o, 8'h85);
    wait_neg(f + 960);
    check("tx55_idle_status", D_o, 8'h05);

    // ---- reset mid-frame ----
    arm_req++;
    bus_write(3'd0, 8'h00);
    wait_fall("txrst_start", f);
    wait_neg(f + 150);
    check("txrst_mid", tx_o, 1'b0);
    reset_i = 1'b1;
    step(1);
    check("txrst_tx_o", tx_o, 1'b1);
    reset_i = 1'b0;
    step(1);
    A_i = 3'd1; #1;
    check("txrst_status", D_o, 8'h05);

    // ---- RX 0xA3 with even parity ----
    bus_write(3'd4, 8'h07);
    bus_write(3'd2, 8'h00);
    step(10);
    send_rx({1'b1, 1'b0, 8'hA3, 1'b0}, 11, 20);
    read_check("rx_a3_status", 3'd1, 8'h04);
    read_check("rx_a3_data", 3'd0, 8'hA3);
    read_check("rx_a3_empty", 3'd1, 8'h05);

    // ---- RX 0xA3 with wrong parity ----
    send_rx({1'b1, 1'b1, 8'hA3, 1'b0}, 11, 20);
    read_check("rx_perr_status", 3'd1, 8'h24);
    read_check("rx_perr_cleared", 3'd1, 8'h04);
    read_check("rx_perr_data", 3'd0, 8'hA3);

    // ---- glitch: false start ----
    rx_i = 1'b0;
    step(2);
    rx_i = 1'b1;
    step(40);
    read_check("glitch_status", 3'd1, 8'h05);

    // ---- framing error: stop bit low ----
    send_rx({1'b0, 1'b0, 8'h3C, 1'b0}, 11, 20);
    read_check("frm_status", 3'd1, 8'h44);
    read_check("frm_data", 3'd0, 8'h3C);
    read_check("frm_empty", 3'd1, 8'h05);

    // ---- overrun: fill 4 entries, fifth byte dropped ----
    bus_write(3'd4, 8'h03);
    for (int i = 1; i <= 4; i++) send_rx({2'b11, 1'b1, 8'(i), 1'b0}, 10, 4);
    send_rx({2'b11, 1'b1, 8'h11, 1'b0}, 10, 20);
    read_check("ovr_status", 3'd1, 8'h16);
    for (int i = 1; i <= 4; i++) read_check($sformatf("ovr_data%0d", i), 3'd0, 8'(i));
    read_check("ovr_empty", 3'd1, 8'h05);

    // ---- back-to-back TX, 7N2, 3 bytes, 16-cycle bits ----
    bus_write(3'd4, 8'h12);
    arm_req++;
    bus_write(3'd0, 8'h41);
    bus_write(3'd0, 8'h7E);
    bus_write(3'd0, 8'hC5);
    wait_fall("b2b_start", f);
    check_frame("b2b", f, 16, {2'b00, fr7n2(8'hC5), fr7n2(8'h7E), fr7n2(8'h41)}, 30);
    A_i = 3'd1;
    wait_neg(f + 479);
    check("b2b_busy_end", D_o, 8'h85);
    wait_neg(f + 480);
    check("b2b_idle_status", D_o, 8'h05);

    // ---- divisor change mid-frame: 3 -> 1 after the third tick of the start bit ----
    bus_write(3'd4, 8'h03);
    bus_write(3'd2, 8'h03);
    step(10);
    arm_req++;
    bus_write(3'd0, 8'h0F);
    wait_fall("div_start", f);
    wait_neg(f + 9);
    bus_write(3'd2, 8'h01);
    wait_neg(f + 20);
    check("div_startbit", tx_o, 1'b0);
    wait_neg(f + 50);
    check("div_d0", tx_o, 1'b1);
    wait_neg(f + 180);
    check("div_d4", tx_o, 1'b0);
    A_i = 3'd1;
    wait_neg(f + 325);
    check("div_busy_end", D_o, 8'h85);
    wait_neg(f + 326);
    check("div_idle_status", D_o, 8'h05);

    // ---- interrupts ----
    bus_write(3'd2, 8'h00);
    bus_write(3'd5, 8'h01);
    step(2);
    check("irq_idle_off", interrupt_o, 1'b0);
    send_rx({2'b11, 1'b1, 8'h5A, 1'b0}, 9, 0);
    A_i = 3'd1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      found = !D_o[0];
    end
    check("irq_rx_seen", D_o[0], 1'b0);
    check("irq_lag", interrupt_o, 1'b0);
    step(1);
    check("irq_rise", interrupt_o, 1'b1);
    read_check("irq_data", 3'd0, 8'h5A);
    check("irq_drop", interrupt_o, 1'b0);
    bus_write(3'd5, 8'h02);
    step(1);
    check("irq_txidle", interrupt_o, 1'b1);
    bus_write(3'd5, 8'h04);
    step(1);
    check("irq_noerr", interrupt_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
